ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 clrn  input  1  reset; asynchronous, active-low.
REQ-003 ps2_clk  input  1  raw PS/2 clock from keyboard; asynchronous to clk.
REQ-004 ps2_data  input  1  raw PS/2 data; asynchronous to clk.
REQ-005 rd_en  input  1  pop request; consumer has taken the head byte.
REQ-006 data  output  8  head-of-FIFO scan code, bits [3:0] and [7:4] each feed one hex seven-segment digit decoder.
REQ-007 ready  output  1  FIFO non-empty; data is valid.
REQ-008 overflow  output  1  sticky; a valid frame was dropped because the FIFO was full.
REQ-009 frame_err  output  1  one-cycle pulse; a completed frame failed the start, stop or parity check.

Parameters
REQ-010 FIFO_DEPTH, default 8, power of two, number of stored bytes.
REQ-011 TIMEOUT, default 4096, idle clk cycles that abort a partial frame.

Function
REQ-012 ps2_clk shall pass through a 3-flop synchronizer; a falling edge is the last two sync stages = 1 then 0.
REQ-013 ps2_data shall be sampled at the synchronizer-aligned point of each detected falling edge.
REQ-014 Receiver states: IDLE (bit count 0), RECV (count 1..10); each falling edge shifts ps2_data into an 11-bit buffer, LSB first, and increments the count.
REQ-015 On the 11th falling edge the frame shall be checked: start bit = 0, stop bit = 1, odd parity over data[7:0] plus the parity bit; the count returns to 0 in the same cycle.
REQ-016 Valid frame with FIFO not full: data[7:0] written at w_ptr, w_ptr+1 mod FIFO_DEPTH, count+1.
REQ-017 Valid frame with FIFO full and no simultaneous pop: byte dropped, overflow set to 1; overflow stays set until reset.
REQ-018 Invalid frame: byte dropped, frame_err high for exactly one clk cycle, FIFO unchanged.
REQ-019 Timeout: in RECV with TIMEOUT consecutive clk cycles and no falling edge, the count and buffer return to IDLE silently (no frame_err).
REQ-020 ready = (FIFO count != 0); data = entry at r_ptr while ready is 1, and 8'h00 while ready is 0.
REQ-021 Latency: ready and data shall reflect a new byte on the clk edge after the cycle that detects the 11th falling edge (1 cycle).
REQ-022 rd_en while ready is 1: r_ptr+1 mod FIFO_DEPTH, count-1; rd_en while ready is 0 is ignored.
REQ-023 Simultaneous pop and valid write: both performed, count unchanged; when full, the write is accepted and overflow is not set.
REQ-024 Pointers shall wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH (width log2(DEPTH)+1).
REQ-025 Bytes shall be delivered in arrival order with no duplication.

Reset
REQ-026 clrn low shall immediately force: ready = 0, data = 8'h00, overflow = 0, frame_err = 0, pointers, counts, buffer and timeout counter = 0, synchronizer flops = 1.
REQ-027 Reset mid-frame shall discard the partial frame; the first complete frame after release shall be received normally.

Verification
REQ-028 Frame for 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> ready = 1 one cycle after the 11th edge, data = 8'h1C, frame_err = 0; rd_en -> ready = 0, data = 8'h00.
REQ-029 Frame for 0x1C with parity bit 1 -> frame_err pulses for 1 cycle, ready stays 0; the next good 0xF0 frame -> data = 8'hF0.
REQ-030 Nine good frames 0x01..0x09 with no reads -> overflow = 1 after the ninth; eight pops return 0x01..0x08 in order, then ready = 0.
REQ-031 5 bits, then idle for 4096 cycles, then a full 0x2A frame -> data = 8'h2A, no frame_err.
REQ-032 With the FIFO full, rd_en coincident with the write cycle of frame 0x55 -> count stays 8, overflow = 0, 0x55 is read last.
REQ-033 clrn pulsed low after 6 bits of a frame -> all outputs 0 during reset; a following 0x1C frame -> data = 8'h1C.

Source files
------------

// File: rtl/ps2_keyboard_if.sv
// PS/2 keyboard receiver bus: raw PS/2 lines, pop handshake and status.
// The master side drives the keyboard lines and pops bytes. The slave side is the receiver.
interface ps2_keyboard_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        output rd_en,
        input  data,
        input  ready,
        input  overflow,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        input  rd_en,
        output data,
        output ready,
        output overflow,
        output frame_err
    );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver.
// Synchronises the raw PS/2 lines and assembles 11-bit frames on falling clock edges.
// It checks start, stop and odd parity, and queues good scan codes in a FIFO for the consumer.
module ps2_keyboard #(
    parameter int FIFO_DEPTH = 8,    // power of two, >= 2
    parameter int TIMEOUT    = 4096  // idle clk cycles that abandon a partial frame
) (
    input  logic          clk,
    input  logic          clrn,
    ps2_keyboard_if.slave kbd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_RECV} rx_state_t;

    // Synchroniser stages: index 0 is newest, index 2 is oldest.
    logic [2:0]    ps2_clk_sync;
    logic [1:0]    ps2_data_sync;
    logic          ps2_fall;
    logic          bit_in;

    // Receiver state.
    rx_state_t     rx_state, rx_state_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [10:0]   shift_buf, shift_buf_nx;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
    logic [10:0]   frame;
    logic          frame_done;
    logic          wr_req;
    logic          err_req;
    logic          frame_err_q;

    // FIFO.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] w_ptr, r_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          overflow_q;
    logic          fifo_full;
    logic          pop;
    logic          push;

    // Bring the asynchronous PS/2 lines into the clk domain. Idle bus level is high.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2_clk_sync  <= 3'b111;
            ps2_data_sync <= 2'b11;
        end else begin
            ps2_clk_sync  <= {ps2_clk_sync[1:0], kbd.ps2_clk};
            ps2_data_sync <= {ps2_data_sync[0], kbd.ps2_data};
        end
    end

    // Data stage 1 lines up with clock stage 1, which is the stage that just went low.
    assign ps2_fall = ps2_clk_sync[2] & ~ps2_clk_sync[1];
    assign bit_in   = ps2_data_sync[1];

    // Frame as it looks with the current bit shifted in (LSB first, enters at the top).
    assign frame = {bit_in, shift_buf[10:1]};

    // Receiver state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rx_state  <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_buf <= 11'd0;
            tmo_cnt   <= '0;
        end else begin
            rx_state  <= rx_state_nx;
            bit_cnt   <= bit_cnt_nx;
            shift_buf <= shift_buf_nx;
            tmo_cnt   <= tmo_cnt_nx;
        end
    end

    // Receiver next state: shift bits on falling edges, close the frame on the 11th edge, and abandon it on timeout.
    always_comb begin
        rx_state_nx  = rx_state;
        bit_cnt_nx   = bit_cnt;
        shift_buf_nx = shift_buf;
        tmo_cnt_nx   = tmo_cnt;
        case (rx_state)
            ST_IDLE: begin
                tmo_cnt_nx = '0;
                if (ps2_fall) begin
                    rx_state_nx  = ST_RECV;
                    bit_cnt_nx   = 4'd1;
                    shift_buf_nx = frame;
                end
            end
            ST_RECV: begin
                if (ps2_fall) begin
                    tmo_cnt_nx = '0;
                    if (bit_cnt == 4'd10) begin
                        rx_state_nx  = ST_IDLE;
                        bit_cnt_nx   = 4'd0;
                        shift_buf_nx = 11'd0;
                    end else begin
                        bit_cnt_nx   = bit_cnt + 4'd1;
                        shift_buf_nx = frame;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    rx_state_nx  = ST_IDLE;
                    bit_cnt_nx   = 4'd0;
                    shift_buf_nx = 11'd0;
                    tmo_cnt_nx   = '0;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
            default: begin
                rx_state_nx  = ST_IDLE;
                bit_cnt_nx   = 4'd0;
                shift_buf_nx = 11'd0;
                tmo_cnt_nx   = '0;
            end
        endcase
    end

    // Receiver outputs: frame check on the closing edge (start 0, stop 1, odd parity over data and parity).
    always_comb begin
        frame_done = 1'b0;
        wr_req     = 1'b0;
        err_req    = 1'b0;
        if (rx_state == ST_RECV && ps2_fall && bit_cnt == 4'd10) begin
            frame_done = 1'b1;
            if (!frame[0] && frame[10] && (^frame[9:1])) begin
                wr_req = 1'b1;
            end else begin
                err_req = 1'b1;
            end
        end
    end

    // Frame error is a single-cycle registered pulse.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= err_req & frame_done;
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept the write.
    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign pop       = kbd.rd_en && (fifo_cnt != '0);
    assign push      = wr_req && (!fifo_full || pop);

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr      <= '0;
            r_ptr      <= '0;
            fifo_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (pop) begin
                r_ptr <= r_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (wr_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage. Contents are masked at the output while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[w_ptr] <= frame[8:1];
        end
    end

    assign kbd.ready     = (fifo_cnt != '0);
    assign kbd.data      = kbd.ready ? mem[r_ptr] : 8'h00;
    assign kbd.overflow  = overflow_q;
    assign kbd.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed testbench for the PS/2 keyboard receiver: table of single frames plus hand sequences.
module tb_ps2_keyboard;

    localparam int HP = 8;  // PS/2 half-bit period in clk cycles

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    ps2_keyboard_if kbd();

    ps2_keyboard #(.FIFO_DEPTH(8), .TIMEOUT(4096)) dut (
        .clk  (clk),
        .clrn (clrn),
        .kbd  (kbd.slave)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;
    int err_hi = 0;

    // Count clk cycles with frame_err high, sampled away from the active edge.
    always @(negedge clk) if (kbd.frame_err === 1'b1) err_hi++;

    typedef struct {
        logic [7:0] code;
        logic       flip_par;
        logic       bad_start;
        logic       bad_stop;
        logic       exp_ready;
        logic [7:0] exp_data;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] code, input logic flip_par,
                                               input logic bad_start, input logic bad_stop);
        return {~bad_stop, (~(^code)) ^ flip_par, code, bad_start};
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        kbd.ps2_data = b;
        repeat (HP) @(negedge clk);
        kbd.ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        kbd.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
    endtask

    // Last falling edge lands at N0; the write happens at the third rising edge after it.
    // rd_en is raised for exactly that cycle.
    task automatic send_frame_pop(input logic [10:0] f);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        @(negedge clk);
        kbd.ps2_data = f[10];
        repeat (HP) @(negedge clk);
        kbd.ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        kbd.rd_en = 1'b1;
        @(negedge clk);
        kbd.rd_en = 1'b0;
        repeat (HP - 3) @(negedge clk);
        kbd.ps2_clk = 1'b1;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        @(negedge clk);
        check({name, " ready"}, 32'(kbd.ready), 32'd1);
        check({name, " data"}, 32'(kbd.data), 32'(exp));
        kbd.rd_en = 1'b1;
        @(negedge clk);
        kbd.rd_en = 1'b0;
    endtask

    initial begin
        int e0;
        logic [10:0] f;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 0};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1};
        vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 0};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vecs[7] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 0};

        kbd.ps2_clk  = 1'b1;
        kbd.ps2_data = 1'b1;
        kbd.rd_en    = 1'b0;
        clrn         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst ready", 32'(kbd.ready), 32'd0);
        check("rst data", 32'(kbd.data), 32'd0);
        check("rst overflow", 32'(kbd.overflow), 32'd0);
        check("rst frame_err", 32'(kbd.frame_err), 32'd0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // Latency: ready rises at the third rising edge after the last PS/2 falling edge.
        f = make_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("frame 1C parity bit", 32'(f[9]), 32'd0);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        @(negedge clk);
        kbd.ps2_data = f[10];
        repeat (HP) @(negedge clk);
        kbd.ps2_clk = 1'b0;
        @(posedge clk); #1;
        check("lat edge1 ready", 32'(kbd.ready), 32'd0);
        @(posedge clk); #1;
        check("lat edge2 ready", 32'(kbd.ready), 32'd0);
        @(posedge clk); #1;
        check("lat edge3 ready", 32'(kbd.ready), 32'd1);
        check("lat edge3 data", 32'(kbd.data), 32'h1C);
        repeat (HP) @(negedge clk);
        kbd.ps2_clk = 1'b1;
        pop_expect("lat pop", 8'h1C);
        @(negedge clk);
        check("lat empty ready", 32'(kbd.ready), 32'd0);
        check("lat empty data", 32'(kbd.data), 32'd0);

        // Single-frame table.
        for (int v = 0; v < 8; v++) begin
            e0 = err_hi;
            send_frame(make_frame(vecs[v].code, vecs[v].flip_par, vecs[v].bad_start, vecs[v].bad_stop), 11);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d ready", v), 32'(kbd.ready), 32'(vecs[v].exp_ready));
            check($sformatf("vec%0d data", v), 32'(kbd.data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d err cycles", v), 32'(err_hi - e0), 32'(vecs[v].exp_err));
            kbd.rd_en = 1'b1;
            @(negedge clk);
            kbd.rd_en = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d after pop ready", v), 32'(kbd.ready), 32'd0);
            check($sformatf("vec%0d after pop data", v), 32'(kbd.data), 32'd0);
        end

        // Nine frames into an 8-deep FIFO with no reads.
        for (int i = 1; i <= 9; i++) begin
            send_frame(make_frame(8'(i), 1'b0, 1'b0, 1'b0), 11);
            repeat (4) @(negedge clk);
            if (i == 8) check("ovf after 8", 32'(kbd.overflow), 32'd0);
        end
        check("ovf after 9", 32'(kbd.overflow), 32'd1);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("ovf pop%0d", i), 8'(i));
        @(negedge clk);
        check("ovf drained ready", 32'(kbd.ready), 32'd0);
        check("ovf sticky", 32'(kbd.overflow), 32'd1);

        // Asynchronous reset in the middle of a frame.
        send_frame(make_frame(8'h33, 1'b0, 1'b0, 1'b0), 11);
        repeat (4) @(negedge clk);
        check("pre-rst ready", 32'(kbd.ready), 32'd1);
        send_frame(make_frame(8'h77, 1'b0, 1'b0, 1'b0), 6);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("midrst ready", 32'(kbd.ready), 32'd0);
        check("midrst data", 32'(kbd.data), 32'd0);
        check("midrst overflow", 32'(kbd.overflow), 32'd0);
        check("midrst frame_err", 32'(kbd.frame_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        e0 = err_hi;
        send_frame(make_frame(8'h1C, 1'b0, 1'b0, 1'b0), 11);
        repeat (4) @(negedge clk);
        check("postrst err cycles", 32'(err_hi - e0), 32'd0);
        pop_expect("postrst pop", 8'h1C);
        @(negedge clk);
        check("postrst empty", 32'(kbd.ready), 32'd0);

        // Partial frame abandoned after the idle timeout.
        send_frame(make_frame(8'hC3, 1'b0, 1'b0, 1'b0), 5);
        repeat (4100) @(negedge clk);
        e0 = err_hi;
        send_frame(make_frame(8'h2A, 1'b0, 1'b0, 1'b0), 11);
        repeat (4) @(negedge clk);
        check("tmo err cycles", 32'(err_hi - e0), 32'd0);
        pop_expect("tmo pop", 8'h2A);
        @(negedge clk);
        check("tmo empty", 32'(kbd.ready), 32'd0);

        // Full FIFO with a pop in the same cycle as the write of 0x55.
        for (int i = 0; i < 8; i++) begin
            send_frame(make_frame(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0), 11);
        end
        repeat (4) @(negedge clk);
        check("full ovf pre", 32'(kbd.overflow), 32'd0);
        send_frame_pop(make_frame(8'h55, 1'b0, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        check("full ovf post", 32'(kbd.overflow), 32'd0);
        for (int i = 1; i < 8; i++) pop_expect($sformatf("full pop%0d", i), 8'h11 + 8'(i));
        pop_expect("full pop last", 8'h55);
        @(negedge clk);
        check("full drained ready", 32'(kbd.ready), 32'd0);
        check("full drained data", 32'(kbd.data), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
